// File: rtl/control_unit.sv
// Multi-cycle control unit: byte-wide 16-bit instruction fetch, single-cycle execute,
// one extra handshake for LOAD/STR, and an absorbing HALT on an undefined opcode.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module control_unit #(
    parameter int WORD_SIZE = `WORD_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic [7:0]           mem_addr,
    output logic                 mem_rd,
    output logic                 mem_wr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic [2:0]           rf_rx_sel,
    output logic [2:0]           rf_ry_sel,
    input  logic [WORD_SIZE-1:0] rf_rx_data,
    input  logic [WORD_SIZE-1:0] rf_ry_data,
    output logic                 rf_wr_en,
    output logic [2:0]           rf_wr_sel,
    output logic [WORD_SIZE-1:0] rf_wr_data,
    output logic [4:0]           alu_opcode,
    output logic [WORD_SIZE-1:0] alu_a,
    output logic [WORD_SIZE-1:0] alu_b,
    input  logic [WORD_SIZE-1:0] alu_out,
    output logic [7:0]           pc,
    output logic [2:0]           flags,
    output logic                 halted
);
    localparam logic [4:0] OP_ADD = 5'b00001, OP_ADC = 5'b00010, OP_SUB = 5'b00011,
                           OP_AND = 5'b00100, OP_OR  = 5'b00101, OP_XOR = 5'b00110,
                           OP_CMP = 5'b00111, OP_MOV = 5'b01000, OP_STR = 5'b10000,
                           OP_LOAD = 5'b10001, OP_JMP = 5'b10100, OP_JC = 5'b10101,
                           OP_JZ  = 5'b10110, OP_JN  = 5'b10111, OP_INC = 5'b11000,
                           OP_DEC = 5'b11001, OP_SHR = 5'b11010, OP_SHL = 5'b11011,
                           OP_SET = 5'b11111;

    typedef enum logic [2:0] {FETCH_HI, FETCH_LO, EXEC, MEM, HALT} state_t;

    state_t                 state;
    logic [15:0]            ir;
    logic [4:0]             op;
    logic [7:0]             m;
    logic [7:0]             pc_next;
    logic                   is_alu;
    logic                   valid;
    logic                   carry;
    logic                   cin;
    logic                   add_c;
    logic                   taken;
    logic [WORD_SIZE-1:0]   res;
    logic [2:0]             new_flags;

    assign op         = ir[15:11];
    assign m          = ir[7:0];
    assign rf_rx_sel  = ir[10:8];
    assign rf_ry_sel  = ir[7:5];
    assign rf_wr_sel  = ir[10:8];
    assign alu_opcode = op;
    assign alu_a      = rf_rx_data;
    assign alu_b      = (op == OP_SHR || op == OP_SHL) ? WORD_SIZE'(1) : rf_ry_data;

    // Carry is derived locally since the ALU only returns a result word.
    assign cin   = (op == OP_ADC) && flags[2];
    assign add_c = ({1'b0, rf_rx_data} + {1'b0, rf_ry_data} + (WORD_SIZE+1)'(cin))
                   > (WORD_SIZE+1)'({WORD_SIZE{1'b1}});

    always_comb begin
        is_alu = 1'b0;
        valid  = 1'b1;
        carry  = 1'b0;
        res    = alu_out;
        case (op)
            OP_ADD, OP_ADC: begin
                is_alu = 1'b1;
                carry  = add_c;
            end
            OP_SUB: begin
                is_alu = 1'b1;
                carry  = rf_rx_data < rf_ry_data;
            end
            OP_CMP: begin
                is_alu = 1'b1;
                carry  = rf_rx_data < rf_ry_data;
                res    = rf_rx_data - rf_ry_data;
            end
            OP_AND, OP_OR, OP_XOR, OP_INC, OP_DEC: is_alu = 1'b1;
            OP_SHR: begin
                is_alu = 1'b1;
                carry  = rf_rx_data[0];
            end
            OP_SHL: begin
                is_alu = 1'b1;
                carry  = rf_rx_data[WORD_SIZE-1];
            end
            OP_MOV, OP_STR, OP_LOAD, OP_JMP, OP_JC, OP_JZ, OP_JN, OP_SET: ;
            default: valid = 1'b0;
        endcase
        if (op == OP_ADC)
            res = alu_out + WORD_SIZE'(flags[2]);
    end

    assign new_flags = {carry, res == '0, res[WORD_SIZE-1]};

    always_comb begin
        case (op)
            OP_JMP:  taken = 1'b1;
            OP_JC:   taken = flags[2];
            OP_JZ:   taken = flags[1];
            OP_JN:   taken = flags[0];
            default: taken = 1'b0;
        endcase
    end

    assign pc_next = taken ? m : pc + 8'd2;

    // Register write is decoded from state so ALU results and LOAD data land in the same cycle.
    assign rf_wr_en = !rst &&
        ((state == EXEC && valid && ((is_alu && op != OP_CMP) || op == OP_MOV || op == OP_SET)) ||
         (state == MEM && op == OP_LOAD && mem_ack));

    always_comb begin
        if (state == MEM)        rf_wr_data = mem_rdata;
        else if (op == OP_MOV)   rf_wr_data = rf_ry_data;
        else if (op == OP_SET)   rf_wr_data = WORD_SIZE'(m);
        else                     rf_wr_data = res;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH_HI;
            pc        <= 8'd0;
            ir        <= 16'd0;
            flags     <= 3'd0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= 8'd0;
            mem_wdata <= '0;
            halted    <= 1'b0;
        end else begin
            case (state)
                FETCH_HI: begin
                    // Only after reset is mem_rd low here; all other entries pre-arm the fetch.
                    if (!mem_rd) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= pc;
                    end else if (mem_ack) begin
                        ir[15:8] <= mem_rdata[7:0];
                        mem_addr <= pc + 8'd1;
                        state    <= FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    if (mem_ack) begin
                        ir[7:0] <= mem_rdata[7:0];
                        mem_rd  <= 1'b0;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (!valid) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else if (op == OP_LOAD) begin
                        mem_rd   <= 1'b1;
                        mem_addr <= m;
                        state    <= MEM;
                    end else if (op == OP_STR) begin
                        mem_wr    <= 1'b1;
                        mem_addr  <= m;
                        mem_wdata <= rf_rx_data;
                        state     <= MEM;
                    end else begin
                        if (is_alu)
                            flags <= new_flags;
                        pc       <= pc_next;
                        mem_rd   <= 1'b1;
                        mem_addr <= pc_next;
                        state    <= FETCH_HI;
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        mem_wr   <= 1'b0;
                        mem_rd   <= 1'b1;
                        mem_addr <= pc + 8'd2;
                        pc       <= pc + 8'd2;
                        state    <= FETCH_HI;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: memory/regfile/ALU models around the DUT and
// scoreboard queues of expected register and memory writes.
module tb_control_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] mem_addr;
    logic       mem_rd, mem_wr, mem_ack;
    logic [7:0] mem_wdata, mem_rdata;
    logic [2:0] rf_rx_sel, rf_ry_sel, rf_wr_sel;
    logic [7:0] rf_rx_data, rf_ry_data, rf_wr_data;
    logic       rf_wr_en;
    logic [4:0] alu_opcode;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [7:0] pc;
    logic [2:0] flags;
    logic       halted;

    control_unit #(.WORD_SIZE(8)) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .rf_rx_sel(rf_rx_sel), .rf_ry_sel(rf_ry_sel),
        .rf_rx_data(rf_rx_data), .rf_ry_data(rf_ry_data),
        .rf_wr_en(rf_wr_en), .rf_wr_sel(rf_wr_sel), .rf_wr_data(rf_wr_data),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .pc(pc), .flags(flags), .halted(halted)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    int         ack_delay = 0;
    int         wait_cnt = 0;
    assign mem_rdata = mem[mem_addr];
    assign mem_ack = (ack_delay == 0) ? 1'b1 : ((mem_rd || mem_wr) && wait_cnt >= ack_delay);
    always @(posedge clk) begin
        if ((mem_rd || mem_wr) && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                                wait_cnt <= 0;
    end

    logic [7:0] rf [8];
    assign rf_rx_data = rf[rf_rx_sel];
    assign rf_ry_data = rf[rf_ry_sel];
    always @(posedge clk) if (rf_wr_en) rf[rf_wr_sel] <= rf_wr_data;

    always_comb begin
        alu_out = 8'h00;
        case (alu_opcode)
            5'b00001, 5'b00010: alu_out = alu_a + alu_b;
            5'b00011, 5'b00111: alu_out = alu_a - alu_b;
            5'b00100: alu_out = alu_a & alu_b;
            5'b00101: alu_out = alu_a | alu_b;
            5'b00110: alu_out = alu_a ^ alu_b;
            5'b11000: alu_out = alu_a + 8'd1;
            5'b11001: alu_out = alu_a - 8'd1;
            5'b11010: alu_out = alu_a >> alu_b;
            5'b11011: alu_out = alu_a << alu_b;
            default:  alu_out = 8'h00;
        endcase
    end

    int          checks = 0;
    int          errors = 0;
    int          memw_cnt = 0;
    logic [10:0] rf_q [$];
    logic [15:0] mem_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle; DUT write outputs are popped against the scoreboards here.
    task automatic tick();
        logic [10:0] erf;
        logic [15:0] emem;
        @(negedge clk);
        if (rf_wr_en) begin
            if (rf_q.size() == 0) check("rf_unexpected_write", rf_wr_en, 1'b0);
            else begin
                erf = rf_q.pop_front();
                check("rf_write", {rf_wr_sel, rf_wr_data}, erf);
            end
        end
        if (mem_wr && mem_ack) begin
            memw_cnt++;
            if (mem_q.size() == 0) check("mem_unexpected_write", mem_wr, 1'b0);
            else begin
                emem = mem_q.pop_front();
                check("mem_write", {mem_addr, mem_wdata}, emem);
            end
        end
        if (mem_rd && mem_wr) check("rd_wr_exclusive", {mem_rd, mem_wr}, 2'b10);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    task automatic put16(input int a, input logic [15:0] w);
        mem[a]     = w[15:8];
        mem[a + 1] = w[7:0];
    endtask

    task automatic start();
        rst = 1'b1;
        tick();
        tick();
        check("rst_pc", pc, 8'h00);
        check("rst_flags", flags, 3'b000);
        check("rst_halted", halted, 1'b0);
        check("rst_mem_req", {mem_rd, mem_wr}, 2'b00);
        check("rst_rf_wr_en", rf_wr_en, 1'b0);
        rst = 1'b0;
        tick();
        check("first_fetch_rd", mem_rd, 1'b1);
        check("first_fetch_addr", mem_addr, 8'h00);
    endtask

    task automatic wait_halt(input int limit);
        int k = 0;
        while (halted !== 1'b1 && k < limit) begin
            tick();
            k++;
        end
        check("halt_reached", halted, 1'b1);
    endtask

    initial begin
        int k;
        int wbefore;
        logic any_req;
        rst = 1'b1;

        // SET R1,5 ; SET R2,3 ; ADD R1,R2 with ack tied high
        ack_delay = 0;
        clear_mem();
        put16(0, 16'hF905); put16(2, 16'hFA03); put16(4, 16'h0940);
        rf_q.push_back({3'd1, 8'h05}); rf_q.push_back({3'd2, 8'h03}); rf_q.push_back({3'd1, 8'h08});
        start();
        repeat (9) tick();
        check("a_pc_after_9", pc, 8'h06);
        check("a_flags", flags, 3'b000);
        wait_halt(50);
        check("a_halt_pc", pc, 8'h06);
        check("a_sb_drained", rf_q.size(), 0);

        // 0xFF + 0x01 sets C and Z, then JC 0x20 taken
        clear_mem();
        put16(0, 16'hF9FF); put16(2, 16'hFA01); put16(4, 16'h0940); put16(6, 16'hA820);
        rf_q.push_back({3'd1, 8'hFF}); rf_q.push_back({3'd2, 8'h01}); rf_q.push_back({3'd1, 8'h00});
        start();
        wait_halt(100);
        check("b_pc", pc, 8'h20);
        check("b_flags", flags, 3'b110);
        check("b_r1", rf[1], 8'h00);
        check("b_sb_drained", rf_q.size(), 0);

        // CMP R3,R3 ; JZ 0x10 taken ; JN 0x30 not taken
        clear_mem();
        put16(0, 16'hFB42); put16(2, 16'h3B60); put16(4, 16'hB010); put16(16, 16'hB830);
        rf_q.push_back({3'd3, 8'h42});
        start();
        wait_halt(100);
        check("c_pc", pc, 8'h12);
        check("c_flags", flags, 3'b010);
        check("c_r3", rf[3], 8'h42);
        check("c_sb_drained", rf_q.size(), 0);

        // SHL carry-out, ADC carry-in, SUB borrow, MOV keeps flags
        clear_mem();
        put16(0, 16'hF981); put16(2, 16'hD900); put16(4, 16'hFA10); put16(6, 16'h1140);
        put16(8, 16'hFD01); put16(10, 16'h1D20); put16(12, 16'h46A0);
        rf_q.push_back({3'd1, 8'h81}); rf_q.push_back({3'd1, 8'h02}); rf_q.push_back({3'd2, 8'h10});
        rf_q.push_back({3'd1, 8'h13}); rf_q.push_back({3'd5, 8'h01}); rf_q.push_back({3'd5, 8'hEE});
        rf_q.push_back({3'd6, 8'hEE});
        start();
        wait_halt(100);
        check("e_pc", pc, 8'h0E);
        check("e_flags", flags, 3'b101);
        check("e_sb_drained", rf_q.size(), 0);

        // LOAD/STR with three wait cycles per request
        ack_delay = 3;
        clear_mem();
        put16(0, 16'h8C80); put16(2, 16'h8481); mem[8'h80] = 8'hA5;
        rf_q.push_back({3'd4, 8'hA5});
        mem_q.push_back({8'h81, 8'hA5});
        wbefore = memw_cnt;
        start();
        k = 0;
        while (!(mem_rd && mem_addr == 8'h80) && k < 60) begin
            tick();
            k++;
        end
        check("d_load_req_seen", {mem_rd, mem_addr}, {1'b1, 8'h80});
        for (int i = 0; i < 3; i++) begin
            tick();
            check("d_load_hold", {mem_rd, mem_wr, mem_addr}, {2'b10, 8'h80});
        end
        wait_halt(200);
        check("d_r4", rf[4], 8'hA5);
        check("d_write_count", memw_cnt - wbefore, 1);
        check("d_pc", pc, 8'h04);
        check("d_sb_drained", rf_q.size() + mem_q.size(), 0);

        // undefined opcode at 0x04, then reset out of HALT
        ack_delay = 0;
        clear_mem();
        put16(0, 16'hF901); put16(2, 16'hFA02);
        rf_q.push_back({3'd1, 8'h01}); rf_q.push_back({3'd2, 8'h02});
        start();
        wait_halt(50);
        check("f_halt_pc", pc, 8'h04);
        any_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            any_req = any_req | mem_rd | mem_wr;
        end
        check("f_no_req_in_halt", any_req, 1'b0);
        check("f_still_halted", halted, 1'b1);
        rst = 1'b1;
        tick();
        check("f_rst_pc", pc, 8'h00);
        check("f_rst_halted", halted, 1'b0);
        check("f_rst_rd", mem_rd, 1'b0);
        rf_q.push_back({3'd1, 8'h01}); rf_q.push_back({3'd2, 8'h02});
        rst = 1'b0;
        tick();
        check("f_refetch", {mem_rd, mem_addr}, {1'b1, 8'h00});
        wait_halt(50);
        check("f_halt_pc2", pc, 8'h04);
        check("f_sb_drained", rf_q.size(), 0);

        // reset while the low-byte fetch is waiting for ack
        ack_delay = 3;
        clear_mem();
        put16(0, 16'hF905); put16(2, 16'hFA03);
        start();
        k = 0;
        while (!(mem_rd && mem_addr == 8'h01) && k < 30) begin
            tick();
            k++;
        end
        check("g_fetch_lo_seen", {mem_rd, mem_addr}, {1'b1, 8'h01});
        rst = 1'b1;
        tick();
        check("g_rst_rd", {mem_rd, mem_wr}, 2'b00);
        check("g_rst_pc", pc, 8'h00);
        check("g_rst_no_wr", rf_wr_en, 1'b0);
        repeat (3) tick();
        check("g_sb_empty", rf_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
